// File: rtl/cpu_div_pkg.sv
// Shared constants and state encoding for the iterative divider.
package cpu_div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_ITERS = 32;

   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_FIN  = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo}, trial subtract, restore.
module div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_rem,
   input  logic [W-1:0] i_quo,
   input  logic [W-1:0] i_dmag,
   output logic [W-1:0] o_rem,
   output logic [W-1:0] o_quo
);

   logic [W:0]   w_sh;
   logic [W+1:0] w_diff;
   logic         w_borrow;

   assign w_sh     = {i_rem, i_quo[W-1]};
   assign w_diff   = {1'b0, w_sh} - {2'b00, i_dmag};
   assign w_borrow = w_diff[W+1];

   // On borrow the shifted remainder is below the divisor, so it fits in W bits
   assign o_rem = w_borrow ? w_sh[W-1:0] : w_diff[W-1:0];
   assign o_quo = {i_quo[W-2:0], ~w_borrow};

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring DIV/DIVU unit with HI/LO result registers.
// DIV_ZERO_FASTPATH_EN: divide-by-zero skips the iterations (2-clock latency).
module div_iter
   import cpu_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   div_state_e       r_state;
   div_state_e       w_state_nx;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dmag;
   logic [WIDTH-1:0] r_raw;
   logic             r_qneg;
   logic             r_rneg;
   logic             r_zero;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_busy;
   logic             r_done;
   logic             r_div_zero;

   logic             w_dvd_neg;
   logic             w_dvs_neg;
   logic             w_dvs_zero;
   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dvs_mag;
   logic [WIDTH-1:0] w_rem_nx;
   logic [WIDTH-1:0] w_quo_nx;
   logic             w_last;

   assign w_dvd_neg  = sign & dividend[WIDTH-1];
   assign w_dvs_neg  = sign & divisor[WIDTH-1];
   assign w_dvs_zero = (divisor == '0);
   assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
   assign w_dvs_mag  = w_dvs_neg ? -divisor : divisor;
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

   div_step #(
      .W (WIDTH)
   ) u_step (
      .i_rem  (r_rem),
      .i_quo  (r_quo),
      .i_dmag (r_dmag),
      .o_rem  (w_rem_nx),
      .o_quo  (w_quo_nx)
   );

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         DIV_IDLE: if (start) w_state_nx = DIV_RUN;
         DIV_RUN:  if (w_last) w_state_nx = DIV_FIN;
         DIV_FIN:  w_state_nx = DIV_IDLE;
         default:  w_state_nx = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= DIV_IDLE;
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dmag      <= '0;
         r_raw       <= '0;
         r_qneg      <= 1'b0;
         r_rneg      <= 1'b0;
         r_zero      <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_div_zero  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_done  <= 1'b0;
         unique case (r_state)
            DIV_IDLE: begin
               if (start) begin
                  r_rem  <= '0;
                  r_quo  <= w_dvd_mag;
                  r_dmag <= w_dvs_mag;
                  r_raw  <= dividend;
                  r_qneg <= w_dvd_neg ^ w_dvs_neg;
                  r_rneg <= w_dvd_neg;
                  r_zero <= w_dvs_zero;
                  r_busy <= 1'b1;
`ifdef DIV_ZERO_FASTPATH_EN
                  // Preloading the last count leaves a single throwaway step
                  r_cnt  <= w_dvs_zero ? CNT_W'(WIDTH - 1) : '0;
`else
                  r_cnt  <= '0;
`endif
               end
            end
            DIV_RUN: begin
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx;
               r_cnt <= r_cnt + 1'b1;
            end
            DIV_FIN: begin
               if (r_zero) begin
                  r_quotient  <= '1;
                  r_remainder <= r_raw;
               end else begin
                  r_quotient  <= r_qneg ? -r_quo : r_quo;
                  r_remainder <= r_rneg ? -r_rem : r_rem;
               end
               r_div_zero <= r_zero;
               r_done     <= 1'b1;
               r_busy     <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign quotient  = r_quotient;
   assign remainder = r_remainder;
   assign busy      = r_busy;
   assign done      = r_done;
   assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_div_iter.sv
// Directed-vector bench for div_iter.
module tb_div_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sign = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        done;
   logic        div_zero;

   int checks = 0;
   int fails  = 0;

`ifdef DIV_ZERO_FASTPATH_EN
   localparam int ZLAT = 2;
`else
   localparam int ZLAT = 33;
`endif

   div_iter dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sign      (sign),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic wait_done(output int lat);
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic do_op(input logic s, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
      @(negedge clk);
      start = 1'b1; sign = s; dividend = a; divisor = b;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat);
   endtask

   task automatic test_reset();
      #1;
      checks += 5;
      if (quotient !== 32'd0) begin fails++; $display("FAIL rst_q got %h exp 0", quotient); end
      if (remainder !== 32'd0) begin fails++; $display("FAIL rst_r got %h exp 0", remainder); end
      if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
      if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b exp 0", done); end
      if (div_zero !== 1'b0) begin fails++; $display("FAIL rst_dz got %b exp 0", div_zero); end
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_divu();
      int lat;
      do_op(1'b0, 32'd100, 32'd7, lat);
      checks += 4;
      if (lat !== 33) begin fails++; $display("FAIL divu_lat got %0d exp 33", lat); end
      if (quotient !== 32'd14) begin fails++; $display("FAIL divu_q got %h exp 0000000e", quotient); end
      if (remainder !== 32'd2) begin fails++; $display("FAIL divu_r got %h exp 00000002", remainder); end
      if (div_zero !== 1'b0) begin fails++; $display("FAIL divu_dz got %b exp 0", div_zero); end
      @(posedge clk); #1;
      checks += 3;
      if (done !== 1'b0) begin fails++; $display("FAIL divu_pulse got %b exp 0", done); end
      if (busy !== 1'b0) begin fails++; $display("FAIL divu_busy got %b exp 0", busy); end
      if (quotient !== 32'd14) begin fails++; $display("FAIL divu_hold got %h exp 0000000e", quotient); end
   endtask

   task automatic test_div_signed();
      int lat;
      do_op(1'b1, 32'hFFFF_FF9C, 32'd7, lat);
      checks += 3;
      if (lat !== 33) begin fails++; $display("FAIL sdiv_lat got %0d exp 33", lat); end
      if (quotient !== 32'hFFFF_FFF2) begin fails++; $display("FAIL sdiv_q got %h exp fffffff2", quotient); end
      if (remainder !== 32'hFFFF_FFFE) begin fails++; $display("FAIL sdiv_r got %h exp fffffffe", remainder); end
   endtask

   task automatic test_overflow();
      int lat;
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      checks += 4;
      if (lat !== 33) begin fails++; $display("FAIL ovf_lat got %0d exp 33", lat); end
      if (quotient !== 32'h8000_0000) begin fails++; $display("FAIL ovf_q got %h exp 80000000", quotient); end
      if (remainder !== 32'd0) begin fails++; $display("FAIL ovf_r got %h exp 0", remainder); end
      if (div_zero !== 1'b0) begin fails++; $display("FAIL ovf_dz got %b exp 0", div_zero); end
   endtask

   task automatic test_div_zero();
      int lat;
      do_op(1'b0, 32'h1234_5678, 32'd0, lat);
      checks += 4;
      if (lat !== ZLAT) begin fails++; $display("FAIL dz_lat got %0d exp %0d", lat, ZLAT); end
      if (quotient !== 32'hFFFF_FFFF) begin fails++; $display("FAIL dz_q got %h exp ffffffff", quotient); end
      if (remainder !== 32'h1234_5678) begin fails++; $display("FAIL dz_r got %h exp 12345678", remainder); end
      if (div_zero !== 1'b1) begin fails++; $display("FAIL dz_flag got %b exp 1", div_zero); end
   endtask

   task automatic test_abort();
      int lat;
      int seen;
      @(negedge clk);
      start = 1'b1; sign = 1'b0; dividend = 32'd50; divisor = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      checks += 2;
      if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy got %b exp 1", busy); end
      if (done !== 1'b0) begin fails++; $display("FAIL abort_early got %b exp 0", done); end
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks += 5;
      if (quotient !== 32'd0) begin fails++; $display("FAIL abort_q got %h exp 0", quotient); end
      if (remainder !== 32'd0) begin fails++; $display("FAIL abort_r got %h exp 0", remainder); end
      if (div_zero !== 1'b0) begin fails++; $display("FAIL abort_dz got %b exp 0", div_zero); end
      if (busy !== 1'b0) begin fails++; $display("FAIL abort_rbusy got %b exp 0", busy); end
      if (done !== 1'b0) begin fails++; $display("FAIL abort_rdone got %b exp 0", done); end
      @(negedge clk); rst = 1'b0;
      seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin fails++; $display("FAIL abort_nodone got %0d exp 0", seen); end
      do_op(1'b0, 32'd9, 32'd3, lat);
      checks += 3;
      if (lat !== 33) begin fails++; $display("FAIL fresh_lat got %0d exp 33", lat); end
      if (quotient !== 32'd3) begin fails++; $display("FAIL fresh_q got %h exp 00000003", quotient); end
      if (remainder !== 32'd0) begin fails++; $display("FAIL fresh_r got %h exp 0", remainder); end
   endtask

   task automatic test_back_to_back();
      int lat;
      int bad;
      do_op(1'b0, 32'hFFFF_FFFF, 32'h10, lat);
      checks += 3;
      if (lat !== 33) begin fails++; $display("FAIL b2b1_lat got %0d exp 33", lat); end
      if (quotient !== 32'h0FFF_FFFF) begin fails++; $display("FAIL b2b1_q got %h exp 0fffffff", quotient); end
      if (remainder !== 32'hF) begin fails++; $display("FAIL b2b1_r got %h exp 0000000f", remainder); end
      start = 1'b1; sign = 1'b0; dividend = 32'd1000; divisor = 32'd10;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      bad = 0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = n;
            break;
         end
         if (quotient !== 32'h0FFF_FFFF || remainder !== 32'hF || busy !== 1'b1) bad++;
      end
      checks += 4;
      if (bad !== 0) begin fails++; $display("FAIL b2b_hold got %0d bad cycles exp 0", bad); end
      if (lat !== 33) begin fails++; $display("FAIL b2b2_lat got %0d exp 33", lat); end
      if (quotient !== 32'd100) begin fails++; $display("FAIL b2b2_q got %h exp 00000064", quotient); end
      if (remainder !== 32'd0) begin fails++; $display("FAIL b2b2_r got %h exp 0", remainder); end
   endtask

   initial begin
      test_reset();
      test_divu();
      test_div_signed();
      test_overflow();
      test_div_zero();
      test_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
